// File: rtl/mult_operand_seq_if.sv
// Signal bundle between the multiplier operand sequencer, its pixel/weight
// memories and the floating-point multiplier it feeds.
interface mult_operand_seq_if #(
  parameter int ADDR_W = 10
) ();
  logic              start;
  logic [ADDR_W-1:0] vec_len;
  logic [ADDR_W-1:0] x_base;
  logic [ADDR_W-1:0] w_base;
  logic              mem_rd;
  logic [ADDR_W-1:0] x_addr;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       x_data;
  logic [31:0]       w_data;
  logic [31:0]       mult_a;
  logic [31:0]       mult_b;
  logic              operation_nd;
  logic              operation_rfd;
  logic              rdy;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    input  start, vec_len, x_base, w_base, x_data, w_data, operation_rfd, rdy,
    output mem_rd, x_addr, w_addr, mult_a, mult_b, operation_nd, busy, done, err
  );

  modport slave (
    output start, vec_len, x_base, w_base, x_data, w_data, operation_rfd, rdy,
    input  mem_rd, x_addr, w_addr, mult_a, mult_b, operation_nd, busy, done, err
  );
endinterface

// File: rtl/mult_operand_seq.sv
// Operand sequencer: fetches pixel/weight pairs from synchronous memories,
// hands them to the float multiplier and tracks outstanding products.
module mult_operand_seq #(
  parameter int ADDR_W  = 10,
  parameter int MAX_OUT = 8
) (
  input logic                clk,
  input logic                rst_n,
  mult_operand_seq_if.master bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    ISSUE = 3'd3,
    DRAIN = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] ZERO_C    = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ONE_C     = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] MAX_OUT_C = ADDR_W'(MAX_OUT);

  state_t            state_r;
  logic [ADDR_W-1:0] len_r;
  logic [ADDR_W-1:0] x_base_r;
  logic [ADDR_W-1:0] w_base_r;
  logic [ADDR_W-1:0] idx_r;
  logic [ADDR_W-1:0] issued_r;
  logic [ADDR_W-1:0] returned_r;
  logic [ADDR_W-1:0] x_addr_r;
  logic [ADDR_W-1:0] w_addr_r;
  logic [31:0]       mult_a_r;
  logic [31:0]       mult_b_r;
  logic              mem_rd_r;
  logic              busy_r;
  logic              done_r;
  logic              err_r;

  logic [ADDR_W-1:0] outstanding_s;
  logic [ADDR_W-1:0] issued_nx_s;
  logic [ADDR_W-1:0] returned_nx_s;
  logic [ADDR_W-1:0] idx_inc_s;
  logic              nd_s;
  logic              rdy_ok_s;
  logic              fetch_ok_nx_s;

  // Issue strobe and look-ahead of the counters as they will be after this edge
  always_comb begin
    nd_s          = 1'b0;
    rdy_ok_s      = 1'b0;
    outstanding_s = issued_r - returned_r;
    issued_nx_s   = issued_r;
    returned_nx_s = returned_r;
    idx_inc_s     = idx_r + ONE_C;
    fetch_ok_nx_s = 1'b0;

    if (state_r == ISSUE) begin
      nd_s = bus.operation_rfd;
    end else begin
      nd_s = 1'b0;
    end

    // A return with nothing in flight is an error, never a count
    if (outstanding_s != ZERO_C) begin
      rdy_ok_s = bus.rdy;
    end else begin
      rdy_ok_s = 1'b0;
    end

    if (nd_s) begin
      issued_nx_s = issued_r + ONE_C;
    end else begin
      issued_nx_s = issued_r;
    end

    if (rdy_ok_s) begin
      returned_nx_s = returned_r + ONE_C;
    end else begin
      returned_nx_s = returned_r;
    end

    fetch_ok_nx_s = ((issued_nx_s - returned_nx_s) < MAX_OUT_C);
  end

  // Sequencer state machine; mem_rd is pre-computed so it is high exactly in
  // FETCH cycles where the outstanding count is below the limit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      len_r      <= ZERO_C;
      x_base_r   <= ZERO_C;
      w_base_r   <= ZERO_C;
      idx_r      <= ZERO_C;
      issued_r   <= ZERO_C;
      returned_r <= ZERO_C;
      x_addr_r   <= ZERO_C;
      w_addr_r   <= ZERO_C;
      mult_a_r   <= 32'h0000_0000;
      mult_b_r   <= 32'h0000_0000;
      mem_rd_r   <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      issued_r   <= issued_nx_s;
      returned_r <= returned_nx_s;
      done_r     <= 1'b0;

      if (bus.rdy && !rdy_ok_s) begin
        err_r <= 1'b1;
      end else begin
        err_r <= err_r;
      end

      case (state_r)
        IDLE: begin
          if (bus.start) begin
            len_r      <= bus.vec_len;
            x_base_r   <= bus.x_base;
            w_base_r   <= bus.w_base;
            idx_r      <= ZERO_C;
            issued_r   <= ZERO_C;
            returned_r <= ZERO_C;
            err_r      <= 1'b0;
            if (bus.vec_len != ZERO_C) begin
              x_addr_r <= bus.x_base;
              w_addr_r <= bus.w_base;
              mem_rd_r <= 1'b1;
              busy_r   <= 1'b1;
              state_r  <= FETCH;
            end else begin
              // Empty vector: the completion pulse goes out on the way through DRAIN
              done_r  <= 1'b1;
              state_r <= DRAIN;
            end
          end else begin
            state_r <= IDLE;
          end
        end

        FETCH: begin
          if (mem_rd_r) begin
            mem_rd_r <= 1'b0;
            state_r  <= LOAD;
          end else begin
            mem_rd_r <= fetch_ok_nx_s;
            state_r  <= FETCH;
          end
        end

        LOAD: begin
          mult_a_r <= bus.x_data;
          mult_b_r <= bus.w_data;
          state_r  <= ISSUE;
        end

        ISSUE: begin
          if (nd_s) begin
            idx_r <= idx_inc_s;
            if (idx_inc_s == len_r) begin
              state_r <= DRAIN;
            end else begin
              x_addr_r <= x_base_r + idx_inc_s;
              w_addr_r <= w_base_r + idx_inc_s;
              mem_rd_r <= fetch_ok_nx_s;
              state_r  <= FETCH;
            end
          end else begin
            state_r <= ISSUE;
          end
        end

        DRAIN: begin
          if (done_r) begin
            state_r <= IDLE;
          end else if (returned_nx_s == len_r) begin
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else begin
            state_r <= DRAIN;
          end
        end

        default: begin
          mem_rd_r <= 1'b0;
          busy_r   <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_rd       = mem_rd_r;
  assign bus.x_addr       = x_addr_r;
  assign bus.w_addr       = w_addr_r;
  assign bus.mult_a       = mult_a_r;
  assign bus.mult_b       = mult_b_r;
  assign bus.operation_nd = nd_s;
  assign bus.busy         = busy_r;
  assign bus.done         = done_r;
  assign bus.err          = err_r;

endmodule

// File: tb/tb_mult_operand_seq.sv
// Randomised bench for mult_operand_seq: two instances (default limit and a
// limit of two), memory models, a rdy scheduler and a transaction-level model.
module tb_mult_operand_seq;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mult_operand_seq_if #(.ADDR_W(AW)) bus_a ();
  mult_operand_seq_if #(.ADDR_W(AW)) bus_b ();

  mult_operand_seq #(.ADDR_W(AW), .MAX_OUT(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  mult_operand_seq #(.ADDR_W(AW), .MAX_OUT(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  logic          sel;
  logic          start;
  logic [AW-1:0] vec_len;
  logic [AW-1:0] x_base;
  logic [AW-1:0] w_base;
  logic          rfd;
  logic          rdy;

  assign bus_a.start         = start & ~sel;
  assign bus_b.start         = start & sel;
  assign bus_a.vec_len       = vec_len;
  assign bus_b.vec_len       = vec_len;
  assign bus_a.x_base        = x_base;
  assign bus_b.x_base        = x_base;
  assign bus_a.w_base        = w_base;
  assign bus_b.w_base        = w_base;
  assign bus_a.operation_rfd = rfd;
  assign bus_b.operation_rfd = rfd;
  assign bus_a.rdy           = rdy & ~sel;
  assign bus_b.rdy           = rdy & sel;

  logic [31:0] xmem [1024];
  logic [31:0] wmem [1024];

  // Synchronous-read memory models, one port pair per instance
  always @(posedge clk) begin
    if (bus_a.mem_rd) begin
      bus_a.x_data <= xmem[bus_a.x_addr];
      bus_a.w_data <= wmem[bus_a.w_addr];
    end
    if (bus_b.mem_rd) begin
      bus_b.x_data <= xmem[bus_b.x_addr];
      bus_b.w_data <= wmem[bus_b.w_addr];
    end
  end

  logic          m_mem_rd, m_nd, m_busy, m_done, m_err;
  logic [AW-1:0] m_xa, m_wa;
  logic [31:0]   m_a, m_b;
  assign m_mem_rd = sel ? bus_b.mem_rd       : bus_a.mem_rd;
  assign m_nd     = sel ? bus_b.operation_nd : bus_a.operation_nd;
  assign m_busy   = sel ? bus_b.busy         : bus_a.busy;
  assign m_done   = sel ? bus_b.done         : bus_a.done;
  assign m_err    = sel ? bus_b.err          : bus_a.err;
  assign m_xa     = sel ? bus_b.x_addr       : bus_a.x_addr;
  assign m_wa     = sel ? bus_b.w_addr       : bus_a.w_addr;
  assign m_a      = sel ? bus_b.mult_a       : bus_a.mult_a;
  assign m_b      = sel ? bus_b.mult_b       : bus_a.mult_b;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_rd"}, m_mem_rd, 1'b0);
    check({tag, "_x_addr"}, m_xa, 10'd0);
    check({tag, "_w_addr"}, m_wa, 10'd0);
    check({tag, "_mult_a"}, m_a, 32'd0);
    check({tag, "_mult_b"}, m_b, 32'd0);
    check({tag, "_nd"}, m_nd, 1'b0);
    check({tag, "_busy"}, m_busy, 1'b0);
    check({tag, "_done"}, m_done, 1'b0);
    check({tag, "_err"}, m_err, 1'b0);
  endtask

  int            nd_cyc[$];
  int            fetch_cyc[$];
  logic [AW-1:0] fetch_xa[$];
  int            done_cyc;

  // One dot-product sequence; cycle c is the period after the edge that samples start
  task automatic run(input logic s, input int len, input int xb, input int wb,
                     input int lat, input int hold, input int rlo, input int rhi,
                     input bit rnd_rfd, input int ovl, input int rst_at);
    int            pend[$];
    int            issued, returned, nfetch, outst, last_rdy, mo, done_cnt;
    logic          prev_nd;
    logic [AW-1:0] xbv, wbv, ea;
    nd_cyc.delete();
    fetch_cyc.delete();
    fetch_xa.delete();
    done_cyc = -1;
    done_cnt = 0;
    issued   = 0;
    returned = 0;
    nfetch   = 0;
    last_rdy = -1;
    prev_nd  = 1'b0;
    xbv      = AW'(xb);
    wbv      = AW'(wb);
    mo       = s ? 2 : 8;
    @(negedge clk);
    sel     = s;
    vec_len = AW'(len);
    x_base  = xbv;
    w_base  = wbv;
    rfd     = 1'b1;
    rdy     = 1'b0;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 2000; c++) begin
      if (rnd_rfd) rfd = ($urandom_range(0, 3) != 0);
      else         rfd = !(c >= rlo && c <= rhi);
      outst = issued - returned;
      rdy   = 1'b0;
      if (pend.size() > 0 && pend[0] <= c && c >= hold) begin
        void'(pend.pop_front());
        rdy      = 1'b1;
        returned = returned + 1;
        last_rdy = c;
      end
      start = (c == ovl);
      if (c == rst_at) begin
        rst_n = 1'b0;
        rdy   = 1'b0;
        start = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        return;
      end
      #1;
      if (c == 1 && len != 0) begin
        check("busy_c1", m_busy, 1'b1);
        check("err_cleared", m_err, 1'b0);
      end
      if (rlo == 3 && c >= 3 && c <= 8) begin
        check("hold_a", m_a, xmem[xbv]);
        check("hold_b", m_b, wmem[wbv]);
      end
      if (m_mem_rd) begin
        ea = xbv + AW'(nfetch);
        check("x_addr", m_xa, ea);
        ea = wbv + AW'(nfetch);
        check("w_addr", m_wa, ea);
        check("outst_limit", (outst < mo), 1'b1);
        fetch_cyc.push_back(c);
        fetch_xa.push_back(m_xa);
        nfetch++;
      end
      if (m_nd) begin
        check("nd_gap", prev_nd, 1'b0);
        ea = xbv + AW'(issued);
        check("mult_a", m_a, xmem[ea]);
        ea = wbv + AW'(issued);
        check("mult_b", m_b, wmem[ea]);
        nd_cyc.push_back(c);
        pend.push_back(c + lat);
        issued++;
      end
      prev_nd = m_nd;
      if (m_done) begin
        done_cnt++;
        done_cyc = c;
        check("busy_at_done", m_busy, 1'b0);
        break;
      end
      @(negedge clk);
    end
    rdy   = 1'b0;
    start = 1'b0;
    rfd   = 1'b1;
    check("nd_count", issued, len);
    check("done_count", done_cnt, 1);
    if (len != 0) check("done_cycle", done_cyc, last_rdy + 1);
    else          check("done_cycle_zero", done_cyc, 1);
    @(negedge clk);
    #1;
    check("idle_busy", m_busy, 1'b0);
    check("idle_done", m_done, 1'b0);
    check("idle_mem_rd", m_mem_rd, 1'b0);
  endtask

  initial begin
    rst_n   = 1'b0;
    sel     = 1'b0;
    start   = 1'b0;
    vec_len = '0;
    x_base  = '0;
    w_base  = '0;
    rfd     = 1'b1;
    rdy     = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      xmem[i] = $urandom;
      wmem[i] = $urandom;
    end
    xmem[16]  = 32'h4000_0000;
    wmem[512] = 32'h4040_0000;

    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Basic run: issues at 3/6/9, returns 6 cycles later, done after the third
    run(1'b0, 3, 'h10, 'h200, 6, 0, 0, -1, 1'b0, -1, -1);
    check("basic_nd_n", nd_cyc.size(), 3);
    if (nd_cyc.size() == 3) begin
      check("basic_nd0", nd_cyc[0], 3);
      check("basic_nd1", nd_cyc[1], 6);
      check("basic_nd2", nd_cyc[2], 9);
    end
    check("basic_done", done_cyc, 16);
    if (fetch_cyc.size() > 0) check("basic_fetch0", fetch_cyc[0], 1);

    // Backpressure: rfd low over cycles 3-7
    run(1'b0, 2, 'h10, 'h200, 6, 0, 3, 7, 1'b0, -1, -1);
    if (nd_cyc.size() > 0) check("bp_first_nd", nd_cyc[0], 8);

    // Outstanding limit of two with rdy withheld until cycle 41
    run(1'b1, 4, 'h40, 'h300, 6, 41, 0, -1, 1'b0, -1, -1);
    check("lim_fetch_n", fetch_cyc.size(), 4);
    if (fetch_cyc.size() >= 3) begin
      check("lim_fetch1", fetch_cyc[1], 4);
      check("lim_fetch2", fetch_cyc[2], 42);
    end

    // Zero length, then a start pulse while busy
    run(1'b0, 0, 'h55, 'h66, 6, 0, 0, -1, 1'b0, -1, -1);
    check("zero_nd_n", nd_cyc.size(), 0);
    run(1'b0, 3, 'h20, 'h220, 6, 0, 0, -1, 1'b0, 5, -1);

    // Address wrap-around
    run(1'b0, 2, 1023, 5, 3, 0, 0, -1, 1'b0, -1, -1);
    if (fetch_xa.size() == 2) begin
      check("wrap_xa0", fetch_xa[0], 10'd1023);
      check("wrap_xa1", fetch_xa[1], 10'd0);
    end

    // Spurious rdy in IDLE sets a sticky error, cleared by the next start
    @(negedge clk);
    sel = 1'b0;
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    #1;
    check("spur_err", m_err, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    check("spur_err_held", m_err, 1'b1);
    run(1'b0, 1, 'h30, 'h130, 4, 0, 0, -1, 1'b0, -1, -1);

    // Reset during DRAIN, then a clean sequence
    run(1'b0, 3, 'h10, 'h200, 6, 0, 0, -1, 1'b0, -1, 12);
    @(negedge clk);
    rst_n = 1'b1;
    run(1'b0, 3, 'h10, 'h200, 6, 0, 0, -1, 1'b0, -1, -1);

    // Randomised sequences on both instances
    for (int k = 0; k < 10; k++) begin
      run(1'($urandom_range(0, 1)), $urandom_range(1, 20), $urandom_range(0, 1023),
          $urandom_range(0, 1023), $urandom_range(1, 12), 0, 0, -1, 1'b1, -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mult_operand_seq.md
# mult_operand_seq

Operand sequencer directly upstream of the single-precision floating-point multiplier `mult` in the character-recognition datapath. On `start`, it fetches `vec_len` pixel/weight pairs from two synchronous-read memories and presents each pair on `mult_a`/`mult_b`. It issues each pair with a one-cycle `operation_nd` pulse, honouring `operation_rfd`. It counts the multiplier's `rdy` returns and pulses `done` once every product has come back; the products themselves go to the downstream accumulator.

## Interface
- `ADDR_W`, default 10: width of memory addresses, `vec_len` and the internal counters.
- `MAX_OUT`, default 8: maximum number of issued pairs whose `rdy` has not yet returned.
- `clk`  in  1  rising-edge clock, shared with `mult`.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  begin a dot-product sequence; sampled only in IDLE.
- `vec_len`  in  ADDR_W  number of pairs; captured on accepted `start`.
- `x_base`  in  ADDR_W  pixel memory base address; captured on accepted `start`.
- `w_base`  in  ADDR_W  weight memory base address; captured on accepted `start`.
- `mem_rd`  out  1  read enable to both memories.
- `x_addr`  out  ADDR_W  pixel memory address.
- `w_addr`  out  ADDR_W  weight memory address.
- `x_data`  in  32  pixel word (IEEE-754 single), valid the cycle after `mem_rd`.
- `w_data`  in  32  weight word (IEEE-754 single), valid the cycle after `mem_rd`.
- `mult_a`  out  32  operand a to `mult`.
- `mult_b`  out  32  operand b to `mult`.
- `operation_nd`  out  1  new-data strobe to `mult`.
- `operation_rfd`  in  1  `mult` ready-for-data.
- `rdy`  in  1  `mult` result-valid strobe, one cycle per product.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse once all products have returned.
- `err`  out  1  sticky flag; set by a `rdy` pulse when no pair is outstanding.

## Operation
- The `mult` `sclr` input is not driven by this block; system reset logic owns it.
- State machine has five states: IDLE, FETCH, LOAD, ISSUE, DRAIN.
- IDLE:
  - `start`=1 with `vec_len`≠0: capture `vec_len`, `x_base` and `w_base`; clear `idx`, `issued`, `returned` and `err`; go to FETCH.
  - `start`=1 with `vec_len`=0: go directly to DRAIN, which completes immediately; no `operation_nd` is generated.
- FETCH:
  - If `outstanding` < `MAX_OUT`: `mem_rd`=1, `x_addr`=`x_base`+`idx`, `w_addr`=`w_base`+`idx` (modulo 2^ADDR_W), go to LOAD.
  - Otherwise: `mem_rd`=0, stay in FETCH.
- LOAD: register `x_data`→`mult_a` and `w_data`→`mult_b`; go to ISSUE.
- ISSUE:
  - `operation_nd` = (state==ISSUE) & `operation_rfd`, decoded combinationally.
  - When `operation_nd`=1: `idx`+1, `issued`+1. If `idx`+1 equals `vec_len`, go to DRAIN; otherwise go to FETCH.
  - When `operation_rfd`=0: hold in ISSUE with operands stable.
- DRAIN: wait until `returned` equals the captured `vec_len`; then drive `done`=1 for one cycle and go to IDLE.
- `outstanding` = `issued` − `returned`:
  - `operation_nd` and `rdy` in the same cycle leave it unchanged.
  - `rdy` with `outstanding`=0 sets `err` and does not increment `returned`.
- `start` while `busy` is ignored.
- `mult_a`/`mult_b` change only in LOAD; they hold their value otherwise, including in IDLE.
- Reset mid-operation: all state clears immediately; any products still in flight are not counted afterwards.

## Timing
- Reset values: `mem_rd`=0, `x_addr`=0, `w_addr`=0, `mult_a`=0, `mult_b`=0, `operation_nd`=0, `busy`=0, `done`=0, `err`=0, state IDLE.
- `start` sampled high at edge 0:
  - FETCH in cycle 1: `mem_rd`=1, addresses = bases.
  - LOAD in cycle 2.
  - ISSUE in cycle 3: `operation_nd` asserted if `operation_rfd`=1.
- Best-case throughput is one pair per 3 cycles.
- `done` asserts the cycle after the last `rdy` is counted; `busy` falls in that same cycle.
- With `vec_len`=0, `done` pulses in cycle 1.
- `operation_nd` is never high for two consecutive cycles.

## Test plan
- **Basic run:** `vec_len`=3, `x_base`=0x10, `w_base`=0x200, `operation_rfd`=1, `rdy` returned 6 cycles after each `operation_nd` → exactly 3 `operation_nd` pulses at cycles 3/6/9; addresses 0x10–0x12 and 0x200–0x202; operands match the memory contents (e.g. 0x40000000 × 0x40400000); `done` one cycle after the third `rdy`.
- **Backpressure:** `operation_rfd` low for cycles 3–7 → `operation_nd` first at cycle 8; `mult_a`/`mult_b` unchanged over cycles 3–8.
- **Outstanding limit:** `MAX_OUT`=2, `rdy` withheld for 40 cycles → after 2 issues `mem_rd` stays 0 in FETCH; the third fetch occurs the cycle after the first `rdy`.
- **Zero length and overlapping start:** `vec_len`=0 → `done` at cycle 1, no `operation_nd`; a `start` pulse while `busy` → ignored, pulse count unchanged.
- **Wrap-around and error:** `x_base`=2^ADDR_W−1, `vec_len`=2 → `x_addr` sequence is 1023, then 0. A spurious `rdy` in IDLE → `err`=1, held until the next accepted `start`.
- **Reset mid-operation:** `rst_n`=0 during DRAIN → all outputs return to their reset values asynchronously; a new `start` then runs to completion normally.
